// File: rtl/uc_multiciclo_pkg.sv
// uc_pkg: opcodes, state encoding, ALU commands, mux selects and flag indices for the multicycle control unit
package uc_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [3:0] CMD_ADD   = 4'b0000;
  localparam logic [3:0] CMD_SUB   = 4'b0001;
  localparam logic [3:0] CMD_RTYPE = 4'b0010;
  localparam logic [3:0] CMD_ITYPE = 4'b0011;
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;
  localparam logic [1:0] RF_ALU = 2'b00;
  localparam logic [1:0] RF_MEM = 2'b01;
  localparam logic [1:0] RF_PC4 = 2'b10;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
  function automatic logic is_legal(input logic [6:0] op);
    return op inside {OP_LOAD, OP_STORE, OP_OP, OP_IMM, OP_BRANCH, OP_JAL, OP_JALR};
  endfunction
endpackage

// File: rtl/uc_multiciclo_if.sv
// uc_multiciclo_if: datapath/memory status in, control strobes and selects out
interface uc_multiciclo_if #(parameter int CNT_W = 32);
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [3:0] alu_flags;
  logic i_mem_ready;
  logic d_mem_ready;
  logic pc_load;
  logic [1:0] pc_src;
  logic ir_load;
  logic rf_we;
  logic [1:0] rf_src;
  logic alu_src;
  logic [3:0] alu_cmd;
  logic d_mem_we;
  logic illegal;
  logic [CNT_W-1:0] instret;
  modport master(
    output opcode, funct3, alu_flags, i_mem_ready, d_mem_ready,
    input pc_load, pc_src, ir_load, rf_we, rf_src, alu_src, alu_cmd, d_mem_we, illegal, instret
  );
  modport slave(
    input opcode, funct3, alu_flags, i_mem_ready, d_mem_ready,
    output pc_load, pc_src, ir_load, rf_we, rf_src, alu_src, alu_cmd, d_mem_we, illegal, instret
  );
endinterface

// File: rtl/uc_multiciclo_branch_cond.sv
// branch_cond: decides branch taken from funct3 and the ALU flags of rs1-rs2
module branch_cond
  import uc_pkg::*;
(
  input  logic [2:0] f3,
  input  logic [3:0] flags,
  output logic       taken
);
  logic lt;
  assign lt = flags[FLAG_N] ^ flags[FLAG_V];
  assign taken = f3 == 3'b000 ? flags[FLAG_Z] :
                 f3 == 3'b001 ? !flags[FLAG_Z] :
                 f3 == 3'b100 ? lt :
                 f3 == 3'b101 ? !lt :
                 f3 == 3'b110 ? !flags[FLAG_C] :
                 f3 == 3'b111 ? flags[FLAG_C] : 1'b0;
endmodule

// File: rtl/uc_multiciclo.sv
// uc_multiciclo: multicycle FETCH/DECODE/EXEC/MEM/WB control unit with retired-instruction counter
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  uc_multiciclo_if.slave bus
);
  logic [2:0] state, nxt;
  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic illegal_q, taken;
  logic [CNT_W-1:0] cnt;
  logic pc_load, ir_load, rf_we, alu_src, d_mem_we;
  logic [1:0] pc_src, rf_src;
  logic [3:0] alu_cmd;
  branch_cond u_bc (.f3(f3_q), .flags(bus.alu_flags), .taken(taken));
  // next state and strobes; only the branch pc_src looks at live flags
  always_comb begin
    nxt = state;
    pc_load = 1'b0;
    pc_src = PC_PLUS4;
    ir_load = 1'b0;
    rf_we = 1'b0;
    rf_src = RF_ALU;
    alu_src = 1'b0;
    alu_cmd = CMD_ADD;
    d_mem_we = 1'b0;
    case (state)
      S_FETCH: begin
        ir_load = bus.i_mem_ready;
        nxt = bus.i_mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: nxt = is_legal(bus.opcode) ? S_EXEC : S_HALT;
      S_EXEC:
        case (op_q)
          OP_OP: begin
            alu_cmd = CMD_RTYPE;
            nxt = S_WB;
          end
          OP_IMM: begin
            alu_cmd = CMD_ITYPE;
            alu_src = 1'b1;
            nxt = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src = 1'b1;
            nxt = S_MEM;
          end
          OP_BRANCH: begin
            alu_cmd = CMD_SUB;
            pc_load = 1'b1;
            pc_src = taken ? PC_IMM : PC_PLUS4;
            nxt = S_FETCH;
          end
          OP_JAL: begin
            rf_we = 1'b1;
            rf_src = RF_PC4;
            pc_load = 1'b1;
            pc_src = PC_IMM;
            nxt = S_FETCH;
          end
          OP_JALR: begin
            alu_src = 1'b1;
            rf_we = 1'b1;
            rf_src = RF_PC4;
            pc_load = 1'b1;
            pc_src = PC_ALU;
            nxt = S_FETCH;
          end
          default: nxt = S_HALT;
        endcase
      S_MEM: begin
        alu_src = 1'b1;
        d_mem_we = op_q == OP_STORE;
        pc_load = op_q == OP_STORE && bus.d_mem_ready;
        nxt = !bus.d_mem_ready ? S_MEM : op_q == OP_STORE ? S_FETCH : S_WB;
      end
      S_WB: begin
        pc_load = 1'b1;
        rf_we = 1'b1;
        rf_src = op_q == OP_LOAD ? RF_MEM : RF_ALU;
        alu_cmd = op_q == OP_OP ? CMD_RTYPE : op_q == OP_IMM ? CMD_ITYPE : CMD_ADD;
        alu_src = op_q == OP_IMM;
        nxt = S_FETCH;
      end
      default: nxt = S_HALT;
    endcase
  end
  assign bus.pc_load = pc_load & ~rst;
  assign bus.pc_src = rst ? '0 : pc_src;
  assign bus.ir_load = ir_load & ~rst;
  assign bus.rf_we = rf_we & ~rst;
  assign bus.rf_src = rst ? '0 : rf_src;
  assign bus.alu_src = alu_src & ~rst;
  assign bus.alu_cmd = rst ? '0 : alu_cmd;
  assign bus.d_mem_we = d_mem_we & ~rst;
  assign bus.illegal = illegal_q;
  assign bus.instret = cnt;
  // state, latched instruction fields, sticky illegal flag and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      op_q <= '0;
      f3_q <= '0;
      illegal_q <= 1'b0;
      cnt <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) begin
        op_q <= bus.opcode;
        f3_q <= bus.funct3;
        illegal_q <= illegal_q | !is_legal(bus.opcode);
      end
      if (pc_load) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_uc_multiciclo.sv
// tb_uc_multiciclo: scoreboard bench with randomized instructions and a timing/decision reference model
module tb_uc_multiciclo;
  import uc_pkg::*;
  typedef struct {
    int cyc;
    logic [1:0] pc_src;
    logic [1:0] rf_src;
    logic rf_we;
    logic d_mem_we;
    logic alu_src;
    logic [3:0] alu_cmd;
    logic [31:0] n;
  } rec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uc_multiciclo_if #(.CNT_W(32)) bus ();
  uc_multiciclo #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  rec_t sb[$];
  int cyc = 0;
  int passed = 0;
  int total = 0;
  int nret = 0;
  logic chk_en = 1'b0;
  logic exp_zero = 1'b1;
  logic [3:0] exp_vec = '0;
  logic [6:0] ops[7] = '{OP_LOAD, OP_STORE, OP_OP, OP_IMM, OP_BRANCH, OP_JAL, OP_JALR};
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask
  always @(negedge clk) begin : mon
    rec_t r;
    if (chk_en) chk("strobes", {bus.ir_load, bus.pc_load, bus.rf_we, bus.d_mem_we}, exp_vec);
    if (exp_zero)
      chk("quiet", {bus.pc_load, bus.pc_src, bus.ir_load, bus.rf_we, bus.rf_src,
                    bus.alu_src, bus.alu_cmd, bus.d_mem_we}, 0);
    if (bus.pc_load) begin
      if (sb.size() == 0) chk("unexpected_pc_load", 1, 0);
      else begin
        r = sb.pop_front();
        chk("ret_cycle", cyc, r.cyc);
        chk("pc_src", bus.pc_src, r.pc_src);
        chk("rf_src", bus.rf_src, r.rf_src);
        chk("rf_we", bus.rf_we, r.rf_we);
        chk("d_mem_we", bus.d_mem_we, r.d_mem_we);
        chk("alu_src", bus.alu_src, r.alu_src);
        chk("alu_cmd", bus.alu_cmd, r.alu_cmd);
        chk("instret", bus.instret, r.n);
      end
    end
  end
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int fw, input int dw,
                           input logic [31:0] a, input logic [31:0] b, input int abort_at);
    logic [31:0] d;
    logic tk, legal, wr;
    int ret, last;
    rec_t r;
    d = a - b;
    bus.alu_flags = {(a[31] != b[31]) && (d[31] != a[31]), a >= b, d[31], a == b};
    case (f3)
      3'd0: tk = a == b;
      3'd1: tk = a != b;
      3'd4: tk = $signed(a) < $signed(b);
      3'd5: tk = $signed(a) >= $signed(b);
      3'd6: tk = a < b;
      3'd7: tk = a >= b;
      default: tk = 1'b0;
    endcase
    legal = op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1100111};
    ret = (op == OP_BRANCH || op == OP_JAL || op == OP_JALR) ? fw + 2 :
          op == OP_STORE ? fw + 3 + dw : op == OP_LOAD ? fw + 4 + dw : fw + 3;
    wr = op != OP_BRANCH && op != OP_STORE;
    last = legal ? ret : fw + 21;
    if (legal) begin
      r.cyc = cyc + ret;
      r.pc_src = op == OP_BRANCH ? {1'b0, tk} : op == OP_JAL ? 2'd1 : op == OP_JALR ? 2'd2 : 2'd0;
      r.rf_src = op == OP_LOAD ? 2'd1 : (op == OP_JAL || op == OP_JALR) ? 2'd2 : 2'd0;
      r.rf_we = wr;
      r.d_mem_we = op == OP_STORE;
      r.alu_src = op == OP_IMM || op == OP_JALR || op == OP_STORE;
      r.alu_cmd = op == OP_OP ? 4'd2 : op == OP_IMM ? 4'd3 : op == OP_BRANCH ? 4'd1 : 4'd0;
      r.n = nret;
      nret++;
      sb.push_back(r);
    end
    bus.opcode = op;
    bus.funct3 = f3;
    chk_en = 1'b1;
    for (int c = 0; c <= last; c++) begin
      bus.i_mem_ready = c >= fw;
      bus.d_mem_ready = c >= fw + 3 + dw;
      exp_vec = {c == fw, legal && c == ret, legal && wr && c == ret,
                 legal && op == OP_STORE && c >= fw + 3 && c <= ret};
      exp_zero = !legal && c > fw + 1;
      if (c == abort_at) begin
        rst = 1'b1;
        exp_zero = 1'b1;
        exp_vec = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_zero = 1'b0;
        void'(sb.pop_back());
        nret = 0;
        chk("abort_instret", bus.instret, 0);
        return;
      end
      @(posedge clk);
      #1;
    end
    exp_zero = 1'b0;
    if (!legal) begin
      chk("illegal_set", bus.illegal, 1);
      rst = 1'b1;
      exp_zero = 1'b1;
      exp_vec = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_zero = 1'b0;
      nret = 0;
      chk("illegal_clr", bus.illegal, 0);
      chk("instret_clr", bus.instret, 0);
    end
  endtask
  initial begin
    bus.opcode = '0;
    bus.funct3 = '0;
    bus.alu_flags = '0;
    bus.i_mem_ready = 1'b0;
    bus.d_mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_zero = 1'b0;
    chk("reset_instret", bus.instret, 0);
    chk("reset_illegal", bus.illegal, 0);
    run_instr(OP_OP, 3'd0, 0, 0, 32'd1, 32'd2, -1);
    run_instr(OP_LOAD, 3'd2, 0, 3, 32'd0, 32'd0, -1);
    run_instr(OP_BRANCH, 3'd0, 0, 0, 32'd5, 32'd5, -1);
    run_instr(OP_BRANCH, 3'd1, 0, 0, 32'd5, 32'd5, -1);
    run_instr(OP_BRANCH, 3'd6, 1, 0, 32'd1, 32'd2, -1);
    run_instr(OP_BRANCH, 3'd2, 0, 0, 32'd1, 32'd2, -1);
    run_instr(OP_JALR, 3'd0, 0, 0, 32'd7, 32'd9, -1);
    run_instr(OP_STORE, 3'd2, 0, 2, 32'd3, 32'd3, -1);
    run_instr(7'b1111111, 3'd0, 0, 0, 32'd0, 32'd0, -1);
    run_instr(OP_STORE, 3'd2, 0, 10, 32'd0, 32'd0, 5);
    run_instr(OP_OP, 3'd0, 0, 0, 32'd1, 32'd1, -1);
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, b;
      logic [6:0] op;
      a = $urandom;
      b = $urandom_range(0, 3) == 0 ? a : $urandom;
      op = $urandom_range(0, 40) == 0 ? 7'b0001111 : ops[$urandom_range(0, 6)];
      run_instr(op, 3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), a, b, -1);
    end
    chk_en = 1'b0;
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
